red_pitaya_fads_logger: RTL and testbench

- Downstream stage of the FADS droplet classifier.
- Captures one record per evaluated droplet (id, timestamp, width, intensity, classification) into an on-chip FIFO.
- Software drains the FIFO over the system bus (read head, write pop), so no droplet event is lost between CPU polls.
- Sits in the ADC clock domain next to the classifier and shares its sys_* bus slot region.

---
 rtl/red_pitaya_fads_pkg.sv | 53 +++++
 rtl/red_pitaya_fads_logger_ram.sv | 23 ++
 rtl/red_pitaya_fads_logger.sv | 203 ++++++++++++++++++++
 tb/tb_red_pitaya_fads_logger.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_fads_pkg.sv
// FADS shared definitions: bus address map, record layout,
// CTRL/STATUS bit positions. Used by the classifier and the logger.
package red_pitaya_fads_pkg;

    localparam logic [19:0] ADDR_CTRL   = 20'h00;
    localparam logic [19:0] ADDR_STATUS = 20'h04;
    localparam logic [19:0] ADDR_OVF    = 20'h08;
    localparam logic [19:0] ADDR_HEAD0  = 20'h10;
    localparam logic [19:0] ADDR_HEAD1  = 20'h14;
    localparam logic [19:0] ADDR_HEAD2  = 20'h18;
    localparam logic [19:0] ADDR_HEAD3  = 20'h1C;
    localparam logic [19:0] ADDR_POP    = 20'h20;
    localparam logic [19:0] ADDR_TS     = 20'h24;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_OVF   = 18;

    localparam logic [1:0] W_ID    = 2'd0;
    localparam logic [1:0] W_TS    = 2'd1;
    localparam logic [1:0] W_WIDTH = 2'd2;
    localparam logic [1:0] W_INFO  = 2'd3;

    // w0 sits in the low 32 bits of the 128-bit RAM entry
    typedef struct packed {
        logic [31:0] info;
        logic [31:0] width;
        logic [31:0] ts;
        logic [31:0] id;
    } fads_rec_t;

    function automatic logic [31:0] rec_word(
        input fads_rec_t  r,
        input logic [1:0] idx
    );
        logic [31:0] w;
        case (idx)
            W_ID:    w = r.id;
            W_TS:    w = r.ts;
            W_WIDTH: w = r.width;
            default: w = r.info;
        endcase
        return w;
    endfunction

    function automatic logic is_head(input logic [19:0] a);
        return a inside {ADDR_HEAD0, ADDR_HEAD1, ADDR_HEAD2, ADDR_HEAD3};
    endfunction

endpackage

// File: rtl/red_pitaya_fads_logger_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// No reset so that it maps onto block RAM.
module red_pitaya_fads_logger_ram #(
    parameter int AW = 10,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/red_pitaya_fads_logger.sv
// FADS droplet event logger: per-droplet records into a FIFO,
// drained by software over the sys_* bus.
module red_pitaya_fads_logger #(
    parameter int LOG_DEPTH = 10,
    parameter int DWT       = 14,
    parameter int MEM       = 32
) (
    input  logic                  adc_clk_i,
    input  logic                  adc_rstn_i,
    input  logic                  rec_valid_i,
    input  logic [MEM-1:0]        rec_id_i,
    input  logic [MEM-1:0]        rec_width_i,
    input  logic signed [DWT-1:0] rec_intensity_i,
    input  logic [7:0]            rec_class_i,
    output logic                  full_o,
    output logic                  overflow_o,
    input  logic [31:0]           sys_addr,
    input  logic [31:0]           sys_wdata,
    input  logic [3:0]            sys_sel,
    input  logic                  sys_wen,
    input  logic                  sys_ren,
    output logic [31:0]           sys_rdata,
    output logic                  sys_err,
    output logic                  sys_ack
);

    import red_pitaya_fads_pkg::*;

    localparam int DEPTH = 2**LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] LVL_FULL = (LOG_DEPTH+1)'(DEPTH);

    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH-1:0] rd_addr;
    logic [LOG_DEPTH:0]   level;
    logic [31:0]          ovf_cnt;
    logic [31:0]          ts;
    logic                 ovf_flag;
    logic                 enable;

    logic [19:0] addr;
    logic        sys_en;
    logic        wr_ctrl;
    logic        clr;
    logic        pop_req;
    logic        empty;
    logic        full;
    logic        pop_fire;
    logic        rec_hit;
    logic        push;
    logic        drop;

    fads_rec_t   rec_in;
    fads_rec_t   head_q;
    logic [127:0] ram_q;
    fads_rec_t   byp_rec;
    logic        byp_q;

    logic [31:0] rd_mux;
    logic [31:0] status;
    logic        hd_pend;
    logic [1:0]  hd_idx;
    logic        unused;

    assign addr    = sys_addr[19:0];
    assign sys_en  = sys_wen | sys_ren;
    assign wr_ctrl = sys_wen && (addr == ADDR_CTRL);
    assign clr     = wr_ctrl && sys_wdata[CTRL_CLR];
    assign pop_req = sys_wen && (addr == ADDR_POP);

    assign empty    = (level == '0);
    assign full     = (level == LVL_FULL);
    assign pop_fire = pop_req && !empty && !clr;
    assign rec_hit  = rec_valid_i && enable && !clr;
    // a pop in the same cycle frees the slot for the incoming record
    assign push     = rec_hit && (!full || pop_fire);
    assign drop     = rec_hit && full && !pop_fire;

    assign full_o     = full;
    assign overflow_o = ovf_flag;
    assign sys_err    = 1'b0;

    assign rec_in.id    = 32'(rec_id_i);
    assign rec_in.ts    = ts;
    assign rec_in.width = 32'(rec_width_i);
    assign rec_in.info  = {rec_class_i, 10'b0, 14'(rec_intensity_i)};

    always_comb begin
        rd_addr = rd_ptr;
        if (clr)
            rd_addr = '0;
        else if (pop_fire)
            rd_addr = rd_ptr + 1'b1;
    end

    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ovf_cnt  <= '0;
            ovf_flag <= 1'b0;
            ts       <= '0;
            enable   <= 1'b1;
        end else begin
            ts <= ts + 32'd1;
            if (clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                ovf_cnt  <= '0;
                ovf_flag <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop_fire)
                    rd_ptr <= rd_ptr + 1'b1;
                level <= level + (LOG_DEPTH+1)'(push)
                               - (LOG_DEPTH+1)'(pop_fire);
                if (drop) begin
                    ovf_flag <= 1'b1;
                    if (ovf_cnt != '1)
                        ovf_cnt <= ovf_cnt + 32'd1;
                end
            end
            // a clear write leaves the enable bit as it was
            if (wr_ctrl && !sys_wdata[CTRL_CLR])
                enable <= sys_wdata[CTRL_EN];
        end
    end

    red_pitaya_fads_logger_ram #(
        .AW (LOG_DEPTH),
        .DW (128)
    ) u_ram (
        .clk   (adc_clk_i),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (rec_in),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // forward a record written to the slot being read this cycle
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            byp_q   <= 1'b0;
            byp_rec <= '0;
        end else begin
            byp_q   <= push && (wr_ptr == rd_addr);
            byp_rec <= rec_in;
        end
    end

    always_comb begin
        head_q = '0;
        if (!empty)
            head_q = byp_q ? byp_rec : fads_rec_t'(ram_q);
    end

    always_comb begin
        status = '0;
        status[LOG_DEPTH:0] = level;
        status[ST_EMPTY]    = empty;
        status[ST_FULL]     = full;
        status[ST_OVF]      = ovf_flag;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_CTRL:   rd_mux = {31'b0, enable};
            ADDR_STATUS: rd_mux = status;
            ADDR_OVF:    rd_mux = ovf_cnt;
            ADDR_TS:     rd_mux = ts;
            default:     rd_mux = '0;
        endcase
    end

    // head words take one extra cycle so a preceding pop is visible
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            sys_ack   <= 1'b0;
            sys_rdata <= '0;
            hd_pend   <= 1'b0;
            hd_idx    <= '0;
        end else begin
            hd_pend <= sys_en && is_head(addr);
            hd_idx  <= addr[3:2];
            if (hd_pend) begin
                sys_ack   <= 1'b1;
                sys_rdata <= rec_word(head_q, hd_idx);
            end else begin
                sys_ack <= sys_en && !is_head(addr);
                if (sys_en && !is_head(addr))
                    sys_rdata <= rd_mux;
            end
        end
    end

    assign unused = ^{sys_sel, sys_addr[31:20], sys_wdata[31:2]};

endmodule

// File: tb/tb_red_pitaya_fads_logger.sv
// Bench for the FADS logger: queue-based reference model,
// scoreboard of expected bus responses checked on sys_ack.
module tb_red_pitaya_fads_logger;

    localparam int LD    = 2;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              adc_rstn_i;
    logic              rec_valid_i;
    logic [31:0]       rec_id_i;
    logic [31:0]       rec_width_i;
    logic signed [13:0] rec_intensity_i;
    logic [7:0]        rec_class_i;
    logic              full_o;
    logic              overflow_o;
    logic [31:0]       sys_addr;
    logic [31:0]       sys_wdata;
    logic [3:0]        sys_sel;
    logic              sys_wen;
    logic              sys_ren;
    logic [31:0]       sys_rdata;
    logic              sys_err;
    logic              sys_ack;

    always #5 clk = ~clk;

    red_pitaya_fads_logger #(
        .LOG_DEPTH (LD),
        .DWT       (14),
        .MEM       (32)
    ) dut (
        .adc_clk_i       (clk),
        .adc_rstn_i      (adc_rstn_i),
        .rec_valid_i     (rec_valid_i),
        .rec_id_i        (rec_id_i),
        .rec_width_i     (rec_width_i),
        .rec_intensity_i (rec_intensity_i),
        .rec_class_i     (rec_class_i),
        .full_o          (full_o),
        .overflow_o      (overflow_o),
        .sys_addr        (sys_addr),
        .sys_wdata       (sys_wdata),
        .sys_sel         (sys_sel),
        .sys_wen         (sys_wen),
        .sys_ren         (sys_ren),
        .sys_rdata       (sys_rdata),
        .sys_err         (sys_err),
        .sys_ack         (sys_ack)
    );

    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        logic [31:0] width;
        logic [13:0] inten;
        logic [7:0]  cls;
    } rec_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        bit          chk;
        int          cyc;
        int          lat;
        bit          full;
        bit          ovf;
    } exp_t;

    rec_t        q[$];
    exp_t        sb[$];
    bit          en;
    logic [31:0] ocnt;
    bit          oflag;
    int          cyc;
    logic [31:0] tsm;
    int          n_tests;
    int          n_fail;
    rec_t        z;

    always @(posedge clk) begin
        cyc++;
        if (!adc_rstn_i) tsm <= 0;
        else             tsm <= tsm + 32'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] wd(input rec_t r, input int i);
        case (i)
            0: return r.id;
            1: return r.ts;
            2: return r.width;
            default: return {r.cls, 10'b0, r.inten};
        endcase
    endfunction

    function automatic bit is_hd(input logic [31:0] a);
        return a[19:0] >= 20'h10 && a[19:0] <= 20'h1C && a[1:0] == 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] st;
        case (a[19:0])
            20'h00: return {31'b0, en};
            20'h04: begin
                st = 32'(q.size());
                st[16] = (q.size() == 0);
                st[17] = (q.size() == DEPTH);
                st[18] = oflag;
                return st;
            end
            20'h08: return ocnt;
            20'h10, 20'h14, 20'h18, 20'h1C:
                return q.size() == 0 ? 32'h0 : wd(q[0], int'(a[3:2]));
            20'h24: return tsm;
            default: return 32'h0;
        endcase
    endfunction

    // monitor: every ack consumes one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (sys_ack) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_ack: got ack, expected none");
            end else begin
                e = sb.pop_front();
                if (e.chk) chk(e.name, sys_rdata, e.data);
                chk({e.name, "_lat"}, cyc - e.cyc, e.lat);
                chk({e.name, "_full"}, {31'b0, full_o}, {31'b0, e.full});
                chk({e.name, "_ovf"}, {31'b0, overflow_o}, {31'b0, e.ovf});
                chk({e.name, "_err"}, {31'b0, sys_err}, 32'h0);
            end
        end
    end

    task automatic wait_ack;
        int k;
        k = 0;
        while (sb.size() > 0 && k < 6) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack, expected ack within 6 cycles");
            sb.delete();
        end
    endtask

    task automatic step(input bit rv, input rec_t r, input bit wen,
                        input bit ren, input logic [31:0] a,
                        input logic [31:0] d);
        exp_t e;
        rec_t t;
        bit   clr;
        bit   popf;
        bit   hit;
        rec_valid_i     = rv;
        rec_id_i        = r.id;
        rec_width_i     = r.width;
        rec_intensity_i = r.inten;
        rec_class_i     = r.cls;
        sys_addr        = a;
        sys_wdata       = d;
        sys_wen         = wen;
        sys_ren         = ren;
        sys_sel         = 4'($urandom);
        e.name = $sformatf("%s%02h", ren ? "rd" : "wr", a[7:0]);
        e.data = model_read(a);
        e.chk  = ren;
        e.cyc  = cyc;
        e.lat  = is_hd(a) ? 2 : 1;
        clr  = wen && a[19:0] == 0 && d[1];
        popf = wen && a[19:0] == 20'h20 && q.size() > 0 && !clr;
        hit  = rv && en && !clr;
        if (clr) begin
            q.delete();
            ocnt  = 0;
            oflag = 0;
        end else begin
            if (popf) t = q.pop_front();
            if (hit) begin
                if (q.size() < DEPTH) begin
                    t    = r;
                    t.ts = tsm;
                    q.push_back(t);
                end else begin
                    if (ocnt != 32'hFFFF_FFFF) ocnt++;
                    oflag = 1;
                end
            end
        end
        if (wen && a[19:0] == 0 && !d[1]) en = d[0];
        e.full = (q.size() == DEPTH);
        e.ovf  = oflag;
        if (wen || ren) sb.push_back(e);
        @(posedge clk);
        #1;
        rec_valid_i = 0;
        sys_wen     = 0;
        sys_ren     = 0;
        if (wen || ren) wait_ack();
    endtask

    task automatic push(input rec_t r);
        step(1, r, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [31:0] a);
        step(0, z, 0, 1, a, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(0, z, 1, 0, a, d);
    endtask

    task automatic do_reset;
        adc_rstn_i = 0;
        @(posedge clk);
        #1;
        adc_rstn_i = 1;
        q.delete();
        sb.delete();
        ocnt  = 0;
        oflag = 0;
        en    = 1;
    endtask

    function automatic rec_t mk(input int id, input int w,
                                input int inten, input int cls);
        rec_t r;
        r.id    = 32'(id);
        r.ts    = 0;
        r.width = 32'(w);
        r.inten = 14'(inten);
        r.cls   = 8'(cls);
        return r;
    endfunction

    function automatic rec_t rnd_rec();
        return mk(int'($urandom), int'($urandom),
                  int'($urandom_range(0, 16383)) - 8192,
                  int'($urandom_range(0, 255)));
    endfunction

    logic [31:0] ra [9];

    initial begin
        int          op;
        bit          rv;
        logic [31:0] d;
        logic [31:0] a;
        rec_t        r;
        ra = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14,
               32'h18, 32'h1C, 32'h24, 32'h40};
        z = mk(0, 0, 0, 0);
        n_tests = 0;
        n_fail  = 0;
        cyc = 0;
        adc_rstn_i = 0;
        rec_valid_i = 0;
        rec_id_i = 0;
        rec_width_i = 0;
        rec_intensity_i = 0;
        rec_class_i = 0;
        sys_addr = 0;
        sys_wdata = 0;
        sys_sel = 0;
        sys_wen = 0;
        sys_ren = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        chk("rst_rdata", sys_rdata, 32'h0);
        chk("rst_full", {31'b0, full_o}, 32'h0);
        rd(32'h04);
        rd(32'h00);

        for (int i = 1; i <= 3; i++) push(mk(i, 100, -5, 'h90));
        rd(32'h10);
        rd(32'h14);
        rd(32'h18);
        rd(32'h1C);
        wr(32'h20, 0);
        rd(32'h10);
        rd(32'h04);

        wr(32'h00, 32'h3);
        for (int i = 1; i <= 6; i++) push(mk(i, 10 * i, i, i));
        rd(32'h04);
        rd(32'h08);
        for (int i = 0; i < 4; i++) begin
            rd(32'h10);
            wr(32'h20, 0);
        end
        rd(32'h04);
        rd(32'h10);

        for (int i = 1; i <= 4; i++) push(mk(20 + i, 1, -1, 0));
        step(1, mk(99, 2, 8191, 'hFF), 1, 0, 32'h20, 0);
        rd(32'h04);
        rd(32'h08);
        for (int i = 0; i < 4; i++) begin
            rd(32'h10);
            rd(32'h1C);
            wr(32'h20, 0);
        end

        for (int i = 1; i <= 3; i++) push(mk(40 + i, 5, 3, 1));
        wr(32'h00, 32'h2);
        rd(32'h04);
        rd(32'h00);
        rd(32'h08);
        wr(32'h00, 32'h0);
        push(mk(50, 1, 1, 1));
        rd(32'h04);
        wr(32'h00, 32'h1);
        step(1, mk(51, 1, 1, 1), 1, 0, 32'h0, 32'h3);
        rd(32'h04);

        for (int i = 1; i <= 3; i++) push(mk(60 + i, 7, 7, 7));
        do_reset();
        rd(32'h24);
        rd(32'h04);
        wr(32'h20, 0);
        push(mk(70, 3, -8192, 'h55));
        rd(32'h10);
        rd(32'h14);
        rd(32'h1C);
        rd(32'h04);

        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 9));
            r  = rnd_rec();
            rv = 1'($urandom_range(0, 1));
            a  = $urandom & 32'hFFF0_0000;
            if (op < 4) begin
                push(r);
            end else if (op < 6) begin
                step(rv, r, 1, 0, a | 32'h20, $urandom);
            end else if (op < 9) begin
                rd(a | ra[$urandom_range(0, 8)]);
            end else begin
                d = {30'b0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 3) != 0};
                step(rv, r, 1, 0, a, d);
            end
        end
        wr(32'h00, 32'h1);
        while (q.size() > 0) begin
            rd(32'h10);
            rd(32'h14);
            wr(32'h20, 0);
        end
        rd(32'h04);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
